// File: rtl/regfile_dumper_pkg.sv
// Shared definitions for the register-file debug dumper and its downstream formatter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_dumper_pkg;

  // Default geometry of the CPU register file being dumped.
  localparam int NREGS_DEF  = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  // Dumper FSM state encoding.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Output word layout as packed by the display/UART formatter: {last, addr, data}.
  localparam int WORD_DATA_LSB = 0;
  localparam int WORD_ADDR_LSB = DATA_W_DEF;
  localparam int WORD_LAST_BIT = DATA_W_DEF + ADDR_W_DEF;
  localparam int WORD_W        = DATA_W_DEF + ADDR_W_DEF + 1;

  typedef struct packed {
    logic                  last;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } dump_word_t;

endpackage

// File: rtl/regfile_dumper.sv
// Walks the register-file debug read port (all registers or one) and streams {addr, data} words.
// Latency: start in cycle t -> READ in t+1 -> out_valid from t+2; one word per 2 cycles at full rate.
// Backpressure: out_* held stable while out_valid=1 and out_ready=0; ptr advances only on transfer.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start/single/sel_addr dump request, sampled only in IDLE
//   rf_addr/rf_data      combinational register-file read port (rf_addr tracks ptr)
//   out_valid/out_ready  output handshake; out_addr/out_data/out_last form the word
//   busy                 high whenever not IDLE
//   done                 one-cycle pulse in the cycle after the final word is accepted
module regfile_dumper
  import regfile_dumper_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              single,
  input  logic [ADDR_W-1:0] sel_addr,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREGS - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W-1:0]   r_end_addr;
  logic                r_out_valid;
  logic [ADDR_W-1:0]   r_out_addr;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_last;
  logic                w_xfer;

  assign w_xfer = r_out_valid & out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_READ;
      S_READ:  w_state_nxt = S_SEND;
      S_SEND:  if (w_xfer) w_state_nxt = r_out_last ? S_DONE : S_READ;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pointer, end address and output holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_end_addr  <= '0;
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ptr      <= single ? sel_addr : '0;
            r_end_addr <= single ? sel_addr : LAST_ADDR;
          end
        end
        S_READ: begin
          // rf_data is combinational for rf_addr (= ptr) in this same cycle.
          r_out_data  <= rf_data;
          r_out_addr  <= r_ptr;
          r_out_last  <= (r_ptr == r_end_addr);
          r_out_valid <= 1'b1;
        end
        S_SEND: begin
          if (w_xfer) begin
            r_out_valid <= 1'b0;
            // No increment past the final word, so ptr never wraps.
            if (!r_out_last) r_ptr <= r_ptr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rf_addr   = r_ptr;
  assign out_valid = r_out_valid;
  assign out_addr  = r_out_addr;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_regfile_dumper.sv
`timescale 1ns/1ps
module tb_regfile_dumper;
  import regfile_dumper_pkg::*;

  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          start    = 1'b0;
  logic          single   = 1'b0;
  logic [AW-1:0] sel_addr = '0;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  regfile_dumper #(.NREGS(NREGS), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .single(single), .sel_addr(sel_addr),
    .rf_addr(rf_addr), .rf_data(rf_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Register file environment: write-at-edge, combinational read (read-during-write returns old data).
  logic [DW-1:0] rf_mem [NREGS];
  logic          wr_en   = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  assign rf_data = rf_mem[rf_addr];
  always @(posedge clk) if (wr_en) rf_mem[wr_addr] <= wr_data;

  // Reference model of register contents.
  logic [DW-1:0] model [NREGS];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard.
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } word_t;
  word_t exp_q[$];

  // A dump is the contiguous range lo..hi of the register contents at start time.
  task automatic push_dump(input logic sgl, input logic [AW-1:0] sel);
    int lo;
    int hi;
    lo = sgl ? int'(sel) : 0;
    hi = sgl ? int'(sel) : NREGS - 1;
    for (int i = lo; i <= hi; i++)
      exp_q.push_back('{addr: AW'(i), data: model[i], last: 1'(i == hi)});
  endtask

  // Monitor: samples on negedge, a transfer happens at the following posedge.
  int    n_words  = 0;
  int    n_done   = 0;
  int    exp_done = -1;
  int    hold3    = 0;
  logic  hold_v   = 1'b0;
  word_t hold_w;
  word_t mon_w;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v   = 1'b0;
      exp_done = -1;
    end else begin
      if (hold_v) begin
        chk("hold_valid", 64'(out_valid), 64'(1));
        chk("hold_word", 64'({out_addr, out_data, out_last}), 64'(hold_w));
      end
      hold_v = 1'b0;
      if (out_valid) begin
        chk("rf_addr_tracks_word", 64'(rf_addr), 64'(out_addr));
        if (!out_ready) begin
          hold_v = 1'b1;
          hold_w = '{addr: out_addr, data: out_data, last: out_last};
          if (out_addr == 3) hold3++;
        end else if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got addr %0d data 0x%0h, none expected", out_addr, out_data);
        end else begin
          mon_w = exp_q.pop_front();
          chk("word_addr", 64'(out_addr), 64'(mon_w.addr));
          chk("word_data", 64'(out_data), 64'(mon_w.data));
          chk("word_last", 64'(out_last), 64'(mon_w.last));
          n_words++;
          if (out_last) exp_done = cyc + 1;
        end
      end
      if (done) begin
        n_done++;
        chk("done_timing", 64'(cyc), 64'(exp_done));
        exp_done = -1;
      end else if (exp_done != -1 && cyc >= exp_done) begin
        n_tests++;
        n_fail++;
        $display("FAIL done_missing: no done pulse at cycle %0d", exp_done);
        exp_done = -1;
      end
    end
  end

  // Downstream ready generator.
  int rdy_mode = 0;
  int bp_left  = 0;
  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 3) != 0);
      2: if (out_valid && out_addr == 3 && bp_left > 0) begin
           out_ready = 1'b0;
           bp_left--;
         end else begin
           out_ready = 1'b1;
         end
      default: out_ready = !(out_valid && out_addr == 10);
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rf_write(input int a, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    tick();
    wr_en    = 1'b0;
    model[a] = d;
  endtask

  task automatic issue(input logic sgl, input logic [AW-1:0] sel);
    start    = 1'b1;
    single   = sgl;
    sel_addr = sel;
    push_dump(sgl, sel);
    tick();
    start    = 1'b0;
    single   = 1'($urandom_range(0, 1));
    sel_addr = AW'($urandom_range(0, NREGS - 1));
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: not idle after %0d cycles, %0d words pending", name, budget, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w0;
    int d0;
    int bc;
    int first_v;
    int n;
    logic sgl;
    logic [AW-1:0] sel;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_rf_addr", 64'(rf_addr), 64'(0));
    chk("rst_out_addr", 64'(out_addr), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_last", 64'(out_last), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();

    // Preload reg[i] = 0x100 + i.
    for (int i = 0; i < NREGS; i++) rf_write(i, DW'(32'h100 + i));

    // Full dump, out_ready held high.
    rdy_mode = 0;
    w0 = n_words; d0 = n_done;
    issue(1'b0, '0);
    bc = 0; first_v = -1; n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (!busy) break;
      bc++;
      if (out_valid && first_v < 0) first_v = bc;
    end
    tick();
    // Cycle after start is READ (1), valid appears in the next (2).
    chk("first_valid_cycle", 64'(first_v), 64'(2));
    // 32 words x (READ + SEND) plus the DONE cycle.
    chk("full_busy_cycles", 64'(bc), 64'(2 * NREGS + 1));
    wait_idle("full", 50);
    chk("full_words", 64'(n_words - w0), 64'(NREGS));
    chk("full_done_count", 64'(n_done - d0), 64'(1));

    // Single register dump.
    rf_write(7, 32'hDEADBEEF);
    w0 = n_words; d0 = n_done;
    issue(1'b1, AW'(7));
    wait_idle("single7", 50);
    chk("single_words", 64'(n_words - w0), 64'(1));
    chk("single_done_count", 64'(n_done - d0), 64'(1));

    // Backpressure on addr 3 for 5 cycles.
    rdy_mode = 2; bp_left = 5; hold3 = 0;
    w0 = n_words;
    issue(1'b0, '0);
    wait_idle("backpressure", 300);
    chk("bp_hold_cycles", 64'(hold3), 64'(5));
    chk("bp_words", 64'(n_words - w0), 64'(NREGS));
    rdy_mode = 0;

    // start pulsed while busy, including in the DONE cycle.
    rdy_mode = 1;
    w0 = n_words; d0 = n_done;
    issue(1'b0, '0);
    n = 0;
    do begin
      tick();
      start = busy && (done || $urandom_range(0, 2) == 0);
      n++;
    end while (busy && n < 600);
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("no_restart_busy", 64'(busy), 64'(0));
      tick();
    end
    chk("ignored_start_words", 64'(n_words - w0), 64'(NREGS));
    chk("ignored_start_done", 64'(n_done - d0), 64'(1));
    chk("ignored_start_pending", 64'(exp_q.size()), 64'(0));

    // Reset while addr 10 is pending.
    rdy_mode = 3;
    issue(1'b0, '0);
    n = 0;
    while (!(out_valid && out_addr == 10) && n < 200) begin
      tick();
      n++;
    end
    chk("reached_addr10", 64'(out_valid && out_addr == 10), 64'(1));
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_rf_addr", 64'(rf_addr), 64'(0));
    chk("arst_out_addr", 64'(out_addr), 64'(0));
    chk("arst_out_data", 64'(out_data), 64'(0));
    chk("arst_out_last", 64'(out_last), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    rdy_mode = 0;
    tick();
    w0 = n_words;
    issue(1'b0, '0);
    wait_idle("after_reset", 200);
    chk("after_reset_words", 64'(n_words - w0), 64'(NREGS));

    // Write to reg 5 during its READ cycle: the dump sees the pre-write value.
    w0 = n_words;
    issue(1'b0, '0);
    n = 0;
    while (!(busy && !out_valid && rf_addr == 5) && n < 100) begin
      tick();
      n++;
    end
    chk("reached_read5", 64'(rf_addr), 64'(5));
    rf_write(5, 32'hCAFE0005);
    wait_idle("rdw", 200);
    chk("rdw_words", 64'(n_words - w0), 64'(NREGS));
    issue(1'b1, AW'(5));
    wait_idle("rdw_single", 50);

    // Randomized dumps with random contents and random backpressure.
    rdy_mode = 1;
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < 4; k++) rf_write($urandom_range(0, NREGS - 1), $urandom());
      sgl = 1'($urandom_range(0, 1));
      sel = AW'($urandom_range(0, NREGS - 1));
      w0 = n_words; d0 = n_done;
      issue(sgl, sel);
      wait_idle("random", 400);
      chk("random_words", 64'(n_words - w0), 64'(sgl ? 1 : NREGS));
      chk("random_done", 64'(n_done - d0), 64'(1));
    end

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
